// File: rtl/fpadd_pkg.sv
// Shared types and constants for the fpadd issue sequencer.
package fpadd_pkg;
  localparam int TAG_W = 8;
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} seq_state_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } fp_pair_t;

  typedef struct packed {
    logic [31:0]      sum;
    logic [TAG_W-1:0] tag;
    logic             err;
  } fp_res_t;
endpackage

// File: rtl/fpadd_seq_if.sv
// Operand input, adder issue and result output signals of the sequencer.
interface fpadd_seq_if;
  import fpadd_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic             add_start;
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic [31:0]      add_sum;
  logic             add_done;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_sum;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  modport master (
    input  in_valid, in_a, in_b, add_sum, add_done, out_ready,
    output in_ready, add_start, add_a, add_b, out_valid, out_sum, out_tag, out_err
  );

  modport slave (
    output in_valid, in_a, in_b, add_sum, add_done, out_ready,
    input  in_ready, add_start, add_a, add_b, out_valid, out_sum, out_tag, out_err
  );
endinterface

// File: rtl/fp_operand_fifo.sv
// Synchronous operand-pair FIFO; head is read combinationally, pointers wrap modulo DEPTH.
module fp_operand_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= wdata;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
endmodule

// File: rtl/fpadd_seq.sv
// Buffers operand pairs and issues them one at a time to a multi-cycle fpadd,
// returning tagged results; a watchdog converts a hung adder into a flagged qNaN.
module fpadd_seq
  import fpadd_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 300
) (
  input logic         clk,
  input logic         reset,
  fpadd_seq_if.master bus
);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int WDW = $clog2(TIMEOUT);

  seq_state_e       state, state_n;
  fp_pair_t         head;
  logic             fifo_full, fifo_empty, push, pop, finish, abort;
  logic [CW-1:0]    fifo_count;
  logic [WDW-1:0]   wdog;
  logic [TAG_W-1:0] issue_tag, out_tag;
  logic [31:0]      add_a, add_b, out_sum;
  logic             out_err;

  assign push          = bus.in_valid && !fifo_full;
  assign bus.in_ready  = (fifo_count != CW'(DEPTH));
  assign bus.add_start = (state == ISSUE);
  assign bus.add_a     = add_a;
  assign bus.add_b     = add_b;
  assign bus.out_valid = (state == HOLD);
  assign bus.out_sum   = out_sum;
  assign bus.out_tag   = out_tag;
  assign bus.out_err   = out_err;

  fp_operand_fifo #(.DEPTH(DEPTH), .W($bits(fp_pair_t))) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({bus.in_a, bus.in_b}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // add_done is only looked at in WAIT: fpadd leaves it high until the next start.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    finish  = 1'b0;
    abort   = 1'b0;
    case (state)
      IDLE:  if (!fifo_empty) begin
               pop     = 1'b1;
               state_n = ISSUE;
             end
      ISSUE: state_n = WAIT;
      WAIT:  if (bus.add_done) begin
               finish  = 1'b1;
               state_n = HOLD;
             end else if (wdog == WDW'(TIMEOUT - 1)) begin
               finish  = 1'b1;
               abort   = 1'b1;
               state_n = HOLD;
             end
      HOLD:  if (bus.out_ready) begin
               if (!fifo_empty) begin
                 pop     = 1'b1;
                 state_n = ISSUE;
               end else begin
                 state_n = IDLE;
               end
             end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      add_a     <= '0;
      add_b     <= '0;
      out_sum   <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
      issue_tag <= '0;
      wdog      <= '0;
    end else begin
      state <= state_n;
      if (pop) begin
        add_a <= head.a;
        add_b <= head.b;
      end
      if (state == ISSUE)              wdog <= '0;
      else if (state == WAIT && !finish) wdog <= wdog + 1'b1;
      if (finish) begin
        out_sum   <= abort ? FP_QNAN : bus.add_sum;
        out_err   <= abort;
        out_tag   <= issue_tag;
        issue_tag <= issue_tag + 1'b1;
      end
    end
endmodule

// File: tb/tb_fpadd_seq.sv
// Directed bench for fpadd_seq with a behavioural fpadd stand-in whose latency,
// hang and stuck-done behaviour are selectable per step.
module tb_fpadd_seq;
  import fpadd_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  fpadd_seq_if bus();

  fpadd_seq #(.DEPTH(4), .TIMEOUT(300)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // adder stand-in: 0 = done stub_lat edges after start, 1 = hang, 2 = done stuck high
  int          stub_mode = 0;
  int          stub_lat  = 1;
  int          cnt       = 0;
  logic        done_r    = 1'b0;
  logic        busy      = 1'b0;
  logic [31:0] sum_r     = 32'h0;
  logic [31:0] ra        = 32'h0;
  logic [31:0] rb        = 32'h0;
  fp_res_t     q[$];

  function automatic logic [31:0] fp_ref(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
    if (a == 32'h40000000 && b == 32'hC0000000) return 32'h00000000;
    return a ^ b;
  endfunction

  assign bus.add_sum  = sum_r;
  assign bus.add_done = (stub_mode == 2) ? 1'b1 : done_r;

  always @(posedge clk) begin
    if (bus.add_start) begin
      done_r <= 1'b0;
      busy   <= 1'b1;
      cnt    <= stub_lat;
      ra     <= bus.add_a;
      rb     <= bus.add_b;
    end else if (busy && stub_mode != 1) begin
      if (cnt <= 1) begin
        done_r <= 1'b1;
        sum_r  <= fp_ref(ra, rb);
        busy   <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    fp_res_t r;
    if (!reset && bus.out_valid && bus.out_ready) begin
      r.sum = bus.out_sum;
      r.tag = bus.out_tag;
      r.err = bus.out_err;
      q.push_back(r);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed running expected finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    while (!bus.in_ready && n < 1000) begin
      tick();
      n++;
    end
    chk("push_bound", 32'(n < 1000), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // edges after the push edge until out_valid is seen
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 400) begin
      tick();
      lat++;
    end
  endtask

  task automatic wait_q(input int n);
    int t = 0;
    while (q.size() < n && t < 5000) begin
      tick();
      t++;
    end
    chk("result_count_bound", 32'(q.size() >= n), 32'd1);
  endtask

  task automatic accept();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic reset_pulse();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q.delete();
  endtask

  initial begin
    int lat;
    logic [31:0] a;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;

    // reset state
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_add_start", 32'(bus.add_start), 32'd0);
    chk("rst_add_a",     bus.add_a,          32'h0);
    chk("rst_out_sum",   bus.out_sum,        32'h0);
    chk("rst_out_tag",   32'(bus.out_tag),   32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // single op, minimum latency: out_valid after edge k+4
    push(32'h3F800000, 32'h40000000);
    wait_valid(lat);
    chk("single_lat", 32'(lat), 32'd4);
    chk("single_sum", bus.out_sum, 32'h40400000);
    chk("single_tag", 32'(bus.out_tag), 32'd0);
    chk("single_err", 32'(bus.out_err), 32'd0);
    repeat (3) tick();
    chk("hold_valid",    32'(bus.out_valid), 32'd1);
    chk("hold_sum",      bus.out_sum, 32'h40400000);
    chk("hold_in_ready", 32'(bus.in_ready), 32'd1);
    accept();
    chk("valid_drop", 32'(bus.out_valid), 32'd0);

    // burst of 6 with output stalled: 4 buffered + 1 in flight
    reset_pulse();
    for (int i = 0; i < 5; i++) push(32'(i + 1) << 24, 32'h000000FF);
    chk("burst_full", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    push(32'h06000000, 32'h000000FF);
    wait_q(6);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6 && i < q.size(); i++) begin
      chk("burst_sum", q[i].sum, 32'(i + 1) << 24 | 32'h000000FF);
      chk("burst_tag", 32'(q[i].tag), 32'(i));
      chk("burst_err", 32'(q[i].err), 32'd0);
    end
    tick();

    // hung adder: 300 WAIT cycles, abort after edge k+302
    stub_mode = 1;
    push(32'h3F800000, 32'h3F800000);
    wait_valid(lat);
    chk("to_lat", 32'(lat), 32'd302);
    chk("to_sum", bus.out_sum, 32'h7FC00000);
    chk("to_err", 32'(bus.out_err), 32'd1);
    chk("to_tag", 32'(bus.out_tag), 32'd6);
    accept();
    stub_mode = 0;  // late done arrives now and must be dropped
    repeat (3) tick();
    chk("late_done_ignored", 32'(bus.out_valid), 32'd0);
    push(32'h40000000, 32'hC0000000);
    wait_valid(lat);
    chk("after_to_lat", 32'(lat), 32'd4);
    chk("after_to_sum", bus.out_sum, 32'h00000000);
    chk("after_to_err", 32'(bus.out_err), 32'd0);
    chk("after_to_tag", 32'(bus.out_tag), 32'd7);
    accept();

    // done stuck high: earliest capture is the first WAIT cycle
    stub_mode = 2;
    q.delete();
    push(32'h3F800000, 32'h40000000);
    wait_valid(lat);
    chk("stale_lat", 32'(lat), 32'd3);
    bus.out_ready = 1'b1;
    push(32'h3F800000, 32'h3F800000);
    push(32'h40000000, 32'hC0000000);
    wait_q(3);
    repeat (10) tick();
    bus.out_ready = 1'b0;
    chk("stale_count", 32'(q.size()), 32'd3);
    for (int i = 0; i < 3 && i < q.size(); i++) begin
      chk("stale_tag", 32'(q[i].tag), 32'(8 + i));
      chk("stale_err", 32'(q[i].err), 32'd0);
    end

    // async reset in the middle of WAIT with one more pair buffered
    stub_mode = 1;
    push(32'h3F800000, 32'h40000000);
    push(32'h3F800000, 32'h3F800000);
    repeat (10) tick();
    a = bus.add_a;
    chk("pre_rst_add_a", a, 32'h3F800000);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out_sum",   bus.out_sum,        32'h0);
    chk("mid_rst_out_tag",   32'(bus.out_tag),   32'd0);
    chk("mid_rst_out_err",   32'(bus.out_err),   32'd0);
    chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("mid_rst_add_start", 32'(bus.add_start), 32'd0);
    chk("mid_rst_add_a",     bus.add_a,          32'h0);
    tick();
    reset = 1'b0;
    stub_mode = 0;
    repeat (5) tick();
    chk("flushed_no_issue", 32'(bus.add_start | bus.out_valid), 32'd0);
    push(32'h3F800000, 32'h40000000);
    wait_valid(lat);
    chk("post_rst_tag", 32'(bus.out_tag), 32'd0);
    chk("post_rst_sum", bus.out_sum, 32'h40400000);
    accept();

    // tag wrap across 257 ops; last one is an exact cancellation
    reset_pulse();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 256; i++) push(32'(i), 32'h00000001);
    push(32'h40000000, 32'hC0000000);
    wait_q(257);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 257 && i < q.size(); i++)
      chk("wrap_tag", 32'(q[i].tag), 32'(i % 256));
    if (q.size() >= 257) begin
      chk("cancel_sum", q[256].sum, 32'h00000000);
      chk("cancel_err", 32'(q[256].err), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
